johnson_decoder: RTL and testbench

Receive-side companion to the team's `johnson_counter`: it samples a WIDTH-bit Johnson code each clock and decodes it to a binary state index and a one-hot vector. It flags illegal codes, tracks sequence continuity, and reports lock status and a saturating error count. It sits downstream of any Johnson-coded state bus and acts as the checker/decoder for counters used as sequencers.

---
 rtl/johnson_decoder.sv | 144 ++++++++++++++
 tb/tb_johnson_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes a WIDTH-bit Johnson sample to index/one-hot,
// flags illegal and out-of-sequence codes, tracks lock and a saturating error count.
module johnson_decoder #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    localparam int NS      = 2 * WIDTH,
    localparam int IW      = $clog2(NS)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Code_in,
    input  logic             Code_valid,
    output logic [IW-1:0]    State_out,
    output logic [NS-1:0]    Onehot_out,
    output logic             Valid_out,
    output logic             Illegal_out,
    output logic             Seq_err_out,
    output logic             Locked_out,
    output logic [7:0]       Err_count_out
);

    typedef enum logic {S_UNLOCKED = 1'b0, S_LOCKED = 1'b1} state_t;

    state_t          r_fsm, w_nxt_fsm;
    logic [IW-1:0]   r_prev_idx, w_nxt_prev_idx;
    logic            r_have_prev, w_nxt_have_prev;
    logic [3:0]      r_match_cnt, w_nxt_match_cnt;
    logic [IW-1:0]   r_state, w_nxt_state;
    logic [NS-1:0]   r_onehot, w_nxt_onehot;
    logic            r_valid, w_nxt_valid;
    logic            r_illegal, w_nxt_illegal;
    logic            r_seq_err, w_nxt_seq_err;
    logic [7:0]      r_err_count, w_nxt_err_count;

    logic            w_legal;
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_succ;
    logic            w_in_seq;
    logic [3:0]      w_match_inc;
    logic [7:0]      w_err_inc;

    // Index k < WIDTH+1 is k low ones; above that, (k-WIDTH) low zeros under ones.
    function automatic logic [WIDTH-1:0] code_of(input int k);
        if (k <= WIDTH)
            return WIDTH'((32'd1 << k) - 32'd1);
        else
            return ~WIDTH'((32'd1 << (k - WIDTH)) - 32'd1);
    endfunction

    always_comb begin
        w_legal = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NS; k++) begin
            if (Code_in == code_of(k)) begin
                w_legal = 1'b1;
                w_idx   = IW'(k);
            end
        end
    end

    assign w_succ      = (r_prev_idx == IW'(NS - 1)) ? '0 : r_prev_idx + IW'(1);
    assign w_in_seq    = (w_idx == w_succ);
    assign w_match_inc = r_match_cnt + 4'd1;
    assign w_err_inc   = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

    always_comb begin
        w_nxt_fsm       = r_fsm;
        w_nxt_prev_idx  = r_prev_idx;
        w_nxt_have_prev = r_have_prev;
        w_nxt_match_cnt = r_match_cnt;
        w_nxt_state     = r_state;
        w_nxt_onehot    = r_onehot;
        w_nxt_valid     = 1'b0;
        w_nxt_illegal   = 1'b0;
        w_nxt_seq_err   = 1'b0;
        w_nxt_err_count = r_err_count;
        if (Code_valid) begin
            if (!w_legal) begin
                w_nxt_illegal   = 1'b1;
                w_nxt_err_count = w_err_inc;
                w_nxt_onehot    = '0;
                w_nxt_have_prev = 1'b0;
                w_nxt_match_cnt = '0;
                w_nxt_fsm       = S_UNLOCKED;
            end else begin
                w_nxt_valid     = 1'b1;
                w_nxt_state     = w_idx;
                w_nxt_onehot    = NS'(1) << w_idx;
                w_nxt_prev_idx  = w_idx;
                w_nxt_have_prev = 1'b1;
                if (r_fsm == S_UNLOCKED) begin
                    // A code with no history only seeds prev_idx.
                    if (r_have_prev && w_in_seq) begin
                        w_nxt_match_cnt = w_match_inc;
                        if (w_match_inc >= 4'(LOCK_CNT))
                            w_nxt_fsm = S_LOCKED;
                    end else begin
                        w_nxt_match_cnt = '0;
                    end
                end else if (!w_in_seq) begin
                    w_nxt_seq_err   = 1'b1;
                    w_nxt_err_count = w_err_inc;
                    w_nxt_match_cnt = '0;
                    w_nxt_fsm       = S_UNLOCKED;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_fsm       <= S_UNLOCKED;
            r_prev_idx  <= '0;
            r_have_prev <= 1'b0;
            r_match_cnt <= '0;
            r_state     <= '0;
            r_onehot    <= '0;
            r_valid     <= 1'b0;
            r_illegal   <= 1'b0;
            r_seq_err   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_fsm       <= w_nxt_fsm;
            r_prev_idx  <= w_nxt_prev_idx;
            r_have_prev <= w_nxt_have_prev;
            r_match_cnt <= w_nxt_match_cnt;
            r_state     <= w_nxt_state;
            r_onehot    <= w_nxt_onehot;
            r_valid     <= w_nxt_valid;
            r_illegal   <= w_nxt_illegal;
            r_seq_err   <= w_nxt_seq_err;
            r_err_count <= w_nxt_err_count;
        end
    end

    assign State_out     = r_state;
    assign Onehot_out    = r_onehot;
    assign Valid_out     = r_valid;
    assign Illegal_out   = r_illegal;
    assign Seq_err_out   = r_seq_err;
    assign Locked_out    = (r_fsm == S_LOCKED);
    assign Err_count_out = r_err_count;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder (WIDTH=4, LOCK_CNT=2) with hand-computed expectations.
module tb_johnson_decoder;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] Code_in = 4'h0;
    logic       Code_valid = 1'b0;
    logic [2:0] State_out;
    logic [7:0] Onehot_out;
    logic       Valid_out, Illegal_out, Seq_err_out, Locked_out;
    logic [7:0] Err_count_out;

    int n_chk = 0;
    int n_fail = 0;

    johnson_decoder #(.WIDTH(4), .LOCK_CNT(2)) dut (
        .Clock(Clock), .Reset(Reset), .Code_in(Code_in), .Code_valid(Code_valid),
        .State_out(State_out), .Onehot_out(Onehot_out), .Valid_out(Valid_out),
        .Illegal_out(Illegal_out), .Seq_err_out(Seq_err_out), .Locked_out(Locked_out),
        .Err_count_out(Err_count_out)
    );

    always #5 Clock = ~Clock;

    // {state, onehot, valid, illegal, seq_err, locked, err_count}
    logic [22:0] obs;
    assign obs = {State_out, Onehot_out, Valid_out, Illegal_out, Seq_err_out, Locked_out, Err_count_out};

    function automatic logic [22:0] ev(input int st, input int oh, input bit v, input bit il,
                                       input bit se, input bit lk, input int ec);
        return {3'(st), 8'(oh), v, il, se, lk, 8'(ec)};
    endfunction

    task automatic step(input logic [3:0] c, input logic v);
        Code_in = c;
        Code_valid = v;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        step(4'b0011, 1'b1);
        step(4'b0111, 1'b1);
        n_chk++;
        if (obs !== 23'd0) begin
            n_fail++;
            $display("FAIL reset: got %h expected %h", obs, 23'd0);
        end
        Reset = 1'b0;
    endtask

    task automatic test_lock_in;
        logic [3:0]  c [4];
        logic [22:0] ex [4];
        c  = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};
        ex = '{ev(0, 8'h01, 1, 0, 0, 0, 0), ev(1, 8'h02, 1, 0, 0, 0, 0),
               ev(2, 8'h04, 1, 0, 0, 1, 0), ev(3, 8'h08, 1, 0, 0, 1, 0)};
        for (int i = 0; i < 4; i++) begin
            step(c[i], 1'b1);
            n_chk++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL lock_in[%0d]: got %h expected %h", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_wrap;
        logic [3:0]  c [5];
        logic [22:0] ex [5];
        c  = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        ex = '{ev(4, 8'h10, 1, 0, 0, 1, 0), ev(5, 8'h20, 1, 0, 0, 1, 0),
               ev(6, 8'h40, 1, 0, 0, 1, 0), ev(7, 8'h80, 1, 0, 0, 1, 0),
               ev(0, 8'h01, 1, 0, 0, 1, 0)};
        for (int i = 0; i < 5; i++) begin
            step(c[i], 1'b1);
            n_chk++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_illegal;
        logic [3:0]  c [4];
        logic [22:0] ex [4];
        c  = '{4'b0101, 4'b0001, 4'b0011, 4'b0111};
        ex = '{ev(0, 8'h00, 0, 1, 0, 0, 1), ev(1, 8'h02, 1, 0, 0, 0, 1),
               ev(2, 8'h04, 1, 0, 0, 0, 1), ev(3, 8'h08, 1, 0, 0, 1, 1)};
        for (int i = 0; i < 4; i++) begin
            step(c[i], 1'b1);
            n_chk++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL illegal[%0d]: got %h expected %h", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_skip_stall;
        logic [3:0]  c [16];
        logic [22:0] ex [16];
        c  = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b1111,
               4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b0111};
        ex = '{ev(4, 8'h10, 1, 0, 0, 1, 1), ev(5, 8'h20, 1, 0, 0, 1, 1),
               ev(6, 8'h40, 1, 0, 0, 1, 1), ev(7, 8'h80, 1, 0, 0, 1, 1),
               ev(0, 8'h01, 1, 0, 0, 1, 1), ev(1, 8'h02, 1, 0, 0, 1, 1),
               ev(2, 8'h04, 1, 0, 0, 1, 1), ev(4, 8'h10, 1, 0, 1, 0, 2),
               ev(5, 8'h20, 1, 0, 0, 0, 2), ev(6, 8'h40, 1, 0, 0, 1, 2),
               ev(7, 8'h80, 1, 0, 0, 1, 2), ev(0, 8'h01, 1, 0, 0, 1, 2),
               ev(1, 8'h02, 1, 0, 0, 1, 2), ev(2, 8'h04, 1, 0, 0, 1, 2),
               ev(3, 8'h08, 1, 0, 0, 1, 2), ev(3, 8'h08, 1, 0, 1, 0, 3)};
        for (int i = 0; i < 16; i++) begin
            step(c[i], 1'b1);
            n_chk++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL skip_stall[%0d]: got %h expected %h", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_gating_reset;
        logic [3:0]  c [3];
        logic [22:0] ex [3];
        logic [22:0] hold;
        step(4'b1111, 1'b1);
        step(4'b1110, 1'b1);
        hold = ev(5, 8'h20, 1, 0, 0, 1, 3);
        n_chk++;
        if (obs !== hold) begin
            n_fail++;
            $display("FAIL relock_pre_gate: got %h expected %h", obs, hold);
        end
        hold = ev(5, 8'h20, 0, 0, 0, 1, 3);
        for (int i = 0; i < 5; i++) begin
            step(4'($urandom), 1'b0);
            n_chk++;
            if (obs !== hold) begin
                n_fail++;
                $display("FAIL gate[%0d]: got %h expected %h", i, obs, hold);
            end
        end
        Reset = 1'b1;
        step(4'b1100, 1'b1);
        Reset = 1'b0;
        n_chk++;
        if (obs !== 23'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h expected %h", obs, 23'd0);
        end
        c  = '{4'b1100, 4'b1000, 4'b0000};
        ex = '{ev(6, 8'h40, 1, 0, 0, 0, 0), ev(7, 8'h80, 1, 0, 0, 0, 0),
               ev(0, 8'h01, 1, 0, 0, 1, 0)};
        for (int i = 0; i < 3; i++) begin
            step(c[i], 1'b1);
            n_chk++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL post_reset_relock[%0d]: got %h expected %h", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_saturation;
        int exp_ec = 0;
        Reset = 1'b1;
        step(4'b0000, 1'b0);
        Reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step(4'b1010, 1'b1);
            if (exp_ec < 255) exp_ec++;
            n_chk++;
            if ({Illegal_out, Err_count_out} !== {1'b1, 8'(exp_ec)}) begin
                n_fail++;
                $display("FAIL sat_illegal[%0d]: got il=%0b ec=%0d expected il=1 ec=%0d",
                         i, Illegal_out, Err_count_out, exp_ec);
            end
            step(4'b0000, 1'b1);
            n_chk++;
            if ({Illegal_out, Err_count_out} !== {1'b0, 8'(exp_ec)}) begin
                n_fail++;
                $display("FAIL sat_legal[%0d]: got il=%0b ec=%0d expected il=0 ec=%0d",
                         i, Illegal_out, Err_count_out, exp_ec);
            end
        end
    endtask

    initial begin
        test_reset;
        test_lock_in;
        test_wrap;
        test_illegal;
        test_skip_stall;
        test_gating_reset;
        test_saturation;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
